// File: rtl/k2red_unscale.sv
// K2-RED unscaling stage: T_out = T_in * 2^(2M) mod q, q = qH*2^M + 1.
// Sequential modular doubling, one bit per cycle, valid/ready on both sides.
module k2red_unscale #(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQ-1:0]  T_in,
    input  logic [LOGQH-1:0] qH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  T_out
);

    localparam int M  = LOGQ - LOGQH;
    localparam int CW = $clog2(2 * M + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * M - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DBL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [LOGQ-1:0] x;
    logic [LOGQ-1:0] q;
    logic [CW-1:0]   cnt;

    logic [LOGQ:0]   x2;
    logic            dbl_ge;
    logic [LOGQ-1:0] dbl_x;
    logic [LOGQ-1:0] norm_x;

    // 2x is held at LOGQ+1 bits; when it reaches q the LOGQ-bit wrap of 2x-q is exact.
    always_comb begin
        x2     = {x, 1'b0};
        dbl_ge = x2[LOGQ] | (x2[LOGQ-1:0] >= q);
        dbl_x  = dbl_ge ? (x2[LOGQ-1:0] - q) : x2[LOGQ-1:0];
        norm_x = (x >= q) ? (x - q) : x;
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign T_out     = (state == S_DONE) ? x : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            x     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x     <= T_in;
                        q     <= {qH, {(M - 1){1'b0}}, 1'b1};
                        cnt   <= '0;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    x     <= norm_x;
                    state <= S_DBL;
                end
                S_DBL: begin
                    x   <= dbl_x;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
